// File: rtl/spi_slave_rx.sv
// SPI slave receiver: MSB-first deserialiser into a small rx FIFO, tx byte on miso.
// Optional saturating overflow counter port when SPI_SLAVE_OVF_COUNT_EN is defined.
module spi_slave_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              global_clk,
    input  logic              reset,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overflow
`ifdef SPI_SLAVE_OVF_COUNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_tx_reg;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic              w_last;
    logic [DATA_W-1:0] w_byte;
    logic              w_full;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_last  = !ss && (r_bit_cnt == LAST);
    assign w_byte  = {r_rx_shift, mosi};
    assign w_full  = (r_count == FULL);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_last && (!w_full || w_pop);
    assign w_drop  = w_last && w_full && !w_pop;

    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_tx_reg   <= '0;
        end else begin
            if (tx_load)
                r_tx_reg <= tx_data;
            unique case (r_state)
                S_IDLE:  if (!ss) r_state <= S_SHIFT;
                S_SHIFT: if (ss) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (ss) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= r_tx_reg;
            end else begin
                r_rx_shift <= w_byte[DATA_W-2:0];
                if (w_last) begin
                    r_bit_cnt  <= '0;
                    r_tx_shift <= r_tx_reg;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_byte;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SPI_SLAVE_OVF_COUNT_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset)
            r_ovf_count <= '0;
        else if (w_drop && r_ovf_count != 8'hFF)
            r_ovf_count <= r_ovf_count + 1'b1;
    end

    assign ovf_count = r_ovf_count;
`endif

    assign miso     = ss ? 1'b0 : r_tx_shift[DATA_W-1];
    assign rx_valid = w_valid;
    assign rx_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign busy     = (r_state == S_SHIFT);
    assign overflow = r_overflow;

endmodule
